// File: rtl/spp_concat_stream.sv
// SPP concat back-end: snapshots x, m5, m9, m13 on start and streams their
// channel concatenation one 16-bit element per valid/ready beat.
module spp_concat_stream #(
    parameter int K = 1,
    parameter int H = 1,
    parameter int W = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [0:K*H*W*16-1]                      x,
    input  logic [0:K*H*W*16-1]                      in_m5,
    input  logic [0:K*H*W*16-1]                      in_m9,
    input  logic [0:K*H*W*16-1]                      in_m13,
    output logic [0:15]                              out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [0:((4*K > 1) ? $clog2(4*K) : 1)-1] out_ch,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     done
);

    localparam int DATA_WIDTH = 16;
    localparam int N          = H * W;
    localparam int FLAT       = K * N * DATA_WIDTH;
    localparam int CH_W       = (4 * K > 1) ? $clog2(4 * K) : 1;
    localparam int P_W        = (N > 1) ? $clog2(N) : 1;
    localparam int KW         = (K > 1) ? $clog2(K) : 1;
    localparam int IW         = (FLAT > 1) ? $clog2(FLAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      g_q, g_d;
    logic [KW-1:0]   k_q, k_d;
    logic [P_W-1:0]  p_q, p_d;
    logic            cap;
    logic            last;
    logic [IW-1:0]   base;
    logic [0:FLAT-1] snap_q [4];

    // The channel counter is kept as (group, source channel) so the snapshot
    // select and the element offset need no division.
    assign last = (state_q == S_STREAM) && (g_q == 2'd3) &&
                  (k_q == KW'(K - 1)) && (p_q == P_W'(N - 1));

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        k_d     = k_q;
        p_d     = p_q;
        cap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    cap     = 1'b1;
                    g_d     = '0;
                    k_d     = '0;
                    p_d     = '0;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (last) begin
                        state_d = S_DONE;
                        g_d     = '0;
                        k_d     = '0;
                        p_d     = '0;
                    end else if (p_q == P_W'(N - 1)) begin
                        p_d = '0;
                        if (k_q == KW'(K - 1)) begin
                            k_d = '0;
                            g_d = g_q + 2'd1;
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end else begin
                        p_d = p_q + P_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            k_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            k_q     <= k_d;
            p_q     <= p_d;
        end
    end

    // Snapshot is intentionally not reset; it is only meaningful after a capture.
    always_ff @(posedge clk) begin
        if (reset && cap) begin
            snap_q[0] <= x;
            snap_q[1] <= in_m5;
            snap_q[2] <= in_m9;
            snap_q[3] <= in_m13;
        end
    end

    always_comb begin
        base     = IW'((int'(k_q) * N + int'(p_q)) * DATA_WIDTH);
        out_data = '0;
        out_ch   = '0;
        if (state_q == S_STREAM) begin
            out_data = snap_q[g_q][base +: DATA_WIDTH];
            out_ch   = CH_W'(int'(g_q) * K + int'(k_q));
        end
    end

    assign out_valid = (state_q == S_STREAM);
    assign out_last  = last;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_spp_concat_stream.sv
// Randomized bench for spp_concat_stream: a flat-array reference model gives the
// expected beat sequence; checks ordering, stalls, frame end, start and reset cases.
module tb_spp_concat_stream;

    localparam int K = 2, H = 2, W = 2;
    localparam int N = H * W, E = K * N, T = 4 * E;
    localparam int CHW = $clog2(4 * K);

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [0:E*16-1] x, in_m5, in_m9, in_m13;
    logic [0:15] out_data;
    logic [0:CHW-1] out_ch;
    logic out_valid, out_last, busy, done;

    logic start1 = 1'b0;
    logic [0:15] x1, m5_1, m9_1, m13_1, out_data1;
    logic [0:1] out_ch1;
    logic out_valid1, out_last1, busy1, done1;

    int n_chk = 0, n_err = 0;
    logic [15:0] mem [4][E];
    logic [15:0] exp_q [T];

    always #5 clk = ~clk;

    spp_concat_stream #(.K(K), .H(H), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x(x), .in_m5(in_m5), .in_m9(in_m9), .in_m13(in_m13),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_last(out_last), .busy(busy), .done(done));

    spp_concat_stream #(.K(1), .H(1), .W(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .x(x1), .in_m5(m5_1), .in_m9(m9_1), .in_m13(m13_1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_ch(out_ch1), .out_last(out_last1), .busy(busy1), .done(done1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int i = 0; i < E; i++) begin
            x[i*16 +: 16]      = mem[0][i];
            in_m5[i*16 +: 16]  = mem[1][i];
            in_m9[i*16 +: 16]  = mem[2][i];
            in_m13[i*16 +: 16] = mem[3][i];
        end
    endtask

    // Concatenated stream is just the four maps laid end to end.
    task automatic fill(input bit rnd);
        for (int g = 0; g < 4; g++)
            for (int i = 0; i < E; i++)
                mem[g][i] = rnd ? 16'($urandom) : 16'(16'h1000 * g + i);
        pack();
        for (int b = 0; b < T; b++) exp_q[b] = mem[b / E][b % E];
    endtask

    task automatic launch(input bit hold);
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_valid", out_valid, 1);
        chk("start_ch", out_ch, 0);
        chk("start_data", out_data, exp_q[0]);
    endtask

    task automatic stream(input int pct, input bit hold, input bit poke);
        int beat = 0, cyc = 0;
        bit stalled = 0, rdy;
        logic [15:0] pd;
        logic [0:CHW-1] pc;
        logic pl;
        while (beat < T && cyc < 2000) begin
            chk("valid_hold", out_valid, 1);
            chk("no_early_done", done, 0);
            if (stalled) begin
                chk("stall_data", out_data, pd);
                chk("stall_ch", out_ch, pc);
                chk("stall_last", out_last, pl);
            end
            rdy = ($urandom_range(0, 99) < pct);
            out_ready = rdy;
            start = hold | (poke && beat == 10);
            if (rdy) begin
                chk("data", out_data, exp_q[beat]);
                chk("ch", out_ch, beat / N);
                chk("last", out_last, beat == T - 1);
                beat++;
                stalled = 0;
            end else begin
                stalled = 1;
                pd = out_data;
                pc = out_ch;
                pl = out_last;
            end
            step();
            cyc++;
        end
        chk("frame_beats", beat, T);
        out_ready = 1'b0;
        start = hold;
        chk("end_done", done, 1);
        chk("end_valid", out_valid, 0);
        chk("end_busy", busy, 1);
        step();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        x1 = 16'h0; m5_1 = 16'h0; m9_1 = 16'h0; m13_1 = 16'h0;
        fill(0);
        repeat (2) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        step();

        // basic order
        launch(0);
        stream(100, 0, 0);
        // back-pressure, random data
        fill(1);
        launch(0);
        stream(50, 0, 0);
        // snapshot isolation
        fill(1);
        launch(0);
        x = '1; in_m5 = '1; in_m9 = '1; in_m13 = '1;
        stream(60, 0, 0);
        pack();
        // start while busy
        fill(1);
        launch(0);
        stream(100, 0, 1);
        step();
        chk("poke_no_restart", busy, 0);
        // held start: two frames with one idle cycle between
        fill(0);
        launch(1);
        stream(100, 1, 0);
        launch(0);
        stream(100, 0, 0);

        // reset mid-frame at beat 5
        fill(1);
        launch(0);
        out_ready = 1'b1;
        repeat (5) step();
        chk("mid_data_b5", out_data, exp_q[5]);
        reset = 1'b0;
        step();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_ch", out_ch, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        reset = 1'b1;
        out_ready = 1'b0;
        step();
        chk("post_rst_done", done, 0);
        launch(0);
        stream(70, 0, 0);

        // degenerate K=H=W=1: four beats, last on ch 3
        x1 = 16'hA001; m5_1 = 16'hB002; m9_1 = 16'hC003; m13_1 = 16'hD004;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk("k1_valid", out_valid1, 1);
            chk("k1_data", out_data1, 16'hA001 + 16'h1001 * b);
            chk("k1_ch", out_ch1, b);
            chk("k1_last", out_last1, b == 3);
            step();
        end
        chk("k1_done", done1, 1);
        out_ready = 1'b0;
        step();
        chk("k1_idle", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
